cbus_arbiter_n: RTL and testbench
=================================

Name: cbus_arbiter_n

Overview:
- N-channel arbiter that multiplexes NCH cache-bus masters onto one outgoing cache bus. Typical masters: ibus, dbus, uncached.
- Sits between the core/cache layer and the single bus-to-AXI converter in the AXI build of the CPU top.
- Successor to the fixed two-master arrangement:
  - channel count, address width, data width and burst-length width are all parametrised;
  - supports multi-beat bursts;
  - arbitration policy is selectable.

Parameters:
NCH, 2, number of master channels (2..8)
AW, 32, address width
DW, 32, data width (multiple of 8)
LENW, 4, burst length field width; the field holds beats-1

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
ireq_valid  in  NCH  per-channel request valid
ireq_is_write  in  NCH  per-channel write flag
ireq_addr  in  NCH*AW  per-channel address, channel i at [i*AW +: AW]
ireq_size  in  NCH*3  per-channel beat size (log2 bytes)
ireq_strobe  in  NCH*(DW/8)  per-channel write strobe
ireq_data  in  NCH*DW  per-channel write data
ireq_len  in  NCH*LENW  per-channel beats-1
iresp_ready  out  NCH  per-channel beat accepted/returned
iresp_last  out  NCH  per-channel final beat
iresp_data  out  DW  read data, shared by all channels
oreq_valid  out  1  outgoing request valid
oreq_is_write  out  1  outgoing write flag
oreq_addr  out  AW  outgoing address
oreq_size  out  3  outgoing beat size
oreq_strobe  out  DW/8  outgoing write strobe
oreq_data  out  DW  outgoing write data
oreq_len  out  LENW  outgoing beats-1
oresp_ready  in  1  downstream beat handshake
oresp_last  in  1  downstream final beat
oresp_data  in  DW  downstream read data
busy  out  1  a transaction is granted
grant_idx  out  $clog2(NCH)  index of the granted channel

Behaviour:
- FSM states: IDLE and BUSY. Registers: state, sel, last_grant.
- Reset values: state=IDLE, sel=0, last_grant=NCH-1.
  - Outputs during and after reset: oreq_valid=0, iresp_ready=0, iresp_last=0, busy=0, grant_idx=0.
  - Reset asserted mid-burst: the next cycle is IDLE with all of the above outputs; the burst is abandoned silently.
- IDLE:
  - If any ireq_valid bit is set, pick a winner by policy, load sel and last_grant, and go to BUSY next cycle.
  - In IDLE: oreq_valid=0 and all iresp_ready=0.
- BUSY: oreq_* = channel sel fields, forwarded combinationally.
  - Strobe and data stay live, so write-burst beats may change every cycle.
  - oreq_valid = ireq_valid[sel].
  - iresp_ready[sel] = oresp_ready; iresp_last[sel] = oresp_last.
  - Non-selected channels see ready=0 and last=0.
  - iresp_data = oresp_data at all times.
- BUSY to IDLE when either:
  - oresp_ready & oresp_last in the same cycle; or
  - ireq_valid[sel] drops while BUSY (master abort). Abort is a protocol violation, but the arbiter tolerates it.
- Latency: grant is registered.
  - Request seen in IDLE at cycle t means oreq_valid at t+1.
  - Final beat at t means IDLE at t+1 and the next grant's BUSY at t+2, a minimum one-cycle bubble.
- Default policy is fixed priority: lowest index wins.
- Request inputs of non-granted channels are ignored. Those masters must hold valid and fields stable until their final beat.
- busy=1 exactly in BUSY. grant_idx=sel.

Optional Feature:
- Macro: CBUS_ARB_RR_EN.
- Defined: round-robin. The search starts at (last_grant+1) mod NCH and wraps, so continuously requesting channels are served in rotating order.
- Undefined: fixed priority as above. last_grant is still maintained but unused.

Test Plan:
1. Single read: NCH=2, ch1 valid, addr 0x1FC00000, len=0.
   - Response: oreq_valid=1 with that addr one cycle later; grant_idx=1.
   - Downstream ready+last with data 0xDEADBEEF gives iresp_ready=2'b10, iresp_last[1]=1, iresp_data 0xDEADBEEF.
   - busy=0 the next cycle.
2. Contention, fixed priority: ch0 and ch1 valid in the same cycle.
   - Response: ch0 completes first; one IDLE cycle; then ch1 granted; iresp_ready[1]=0 throughout ch0's transaction.
3. Write burst: ch0 write, len=3, data 0x11,0x22,0x33,0x44, downstream ready every cycle.
   - Response: 4 beats forwarded in order; iresp_last[0] only on beat 4; IDLE after.
4. Round-robin (CBUS_ARB_RR_EN defined): ch0 and ch1 held valid for 4 single-beat transactions.
   - Response: grant sequence 0,1,0,1.
   - With the macro undefined, the same stimulus gives 0,0,0,0.
5. Reset mid-burst: assert reset on beat 2 of a len=3 read.
   - Response: next cycle oreq_valid=0, busy=0, grant_idx=0.
   - After release, a pending ch1 request is granted within 2 cycles.
6. NCH=3: ch2 requests while ch0 is BUSY.
   - Response: iresp_ready[2]=0 until ch0's last beat, then ch2 granted after the bubble with its addr on oreq_addr.

Source files
------------

// File: rtl/cbus_arbiter_n.sv
// cbus_arbiter_n: multiplexes NCH cache-bus masters onto one outgoing cache bus.
//
// Build option:
//   CBUS_ARB_RR_EN  defined   -> round-robin; the search starts after last_grant
//                   undefined -> fixed priority; the lowest index wins
//
// Parameters: NCH masters (2..8), AW address bits, DW data bits, LENW burst field (beats-1).
// Ports:
//   clk, reset                          clock, synchronous active-high reset
//   ireq_*    [NCH-flattened]           per-channel request fields, channel i at [i*W +: W]
//   iresp_ready/iresp_last [NCH]        per-channel beat handshake / final beat
//   iresp_data                          read data, shared by all channels
//   oreq_*                              granted channel's request, forwarded combinationally
//   oresp_ready/oresp_last/oresp_data   downstream beat handshake, final beat, read data
//   busy, grant_idx                     a transaction is granted / granted channel
// Grants are registered. Every transaction is followed by at least one IDLE cycle.

// Per-channel response steering: only the granted channel sees the handshake.
module cbus_arb_lane (
    input  logic hit,
    input  logic oresp_ready,
    input  logic oresp_last,
    output logic resp_ready,
    output logic resp_last
);
    assign resp_ready = hit & oresp_ready;
    assign resp_last  = hit & oresp_last;
endmodule

module cbus_arbiter_n #(
    parameter int NCH  = 2,
    parameter int AW   = 32,
    parameter int DW   = 32,
    parameter int LENW = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NCH-1:0]            ireq_valid,
    input  logic [NCH-1:0]            ireq_is_write,
    input  logic [NCH*AW-1:0]         ireq_addr,
    input  logic [NCH*3-1:0]          ireq_size,
    input  logic [NCH*(DW/8)-1:0]     ireq_strobe,
    input  logic [NCH*DW-1:0]         ireq_data,
    input  logic [NCH*LENW-1:0]       ireq_len,
    output logic [NCH-1:0]            iresp_ready,
    output logic [NCH-1:0]            iresp_last,
    output logic [DW-1:0]             iresp_data,
    output logic                      oreq_valid,
    output logic                      oreq_is_write,
    output logic [AW-1:0]             oreq_addr,
    output logic [2:0]                oreq_size,
    output logic [DW/8-1:0]           oreq_strobe,
    output logic [DW-1:0]             oreq_data,
    output logic [LENW-1:0]           oreq_len,
    input  logic                      oresp_ready,
    input  logic                      oresp_last,
    input  logic [DW-1:0]             oresp_data,
    output logic                      busy,
    output logic [$clog2(NCH)-1:0]    grant_idx
);
    localparam int SW = $clog2(NCH);
    localparam int BW = DW / 8;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state;
    logic [SW-1:0] sel;
    logic [SW-1:0] last_grant;

    // Unpacked views of the flattened request buses so the mux is a plain index.
    logic [AW-1:0]   addr_a   [NCH];
    logic [2:0]      size_a   [NCH];
    logic [BW-1:0]   strobe_a [NCH];
    logic [DW-1:0]   data_a   [NCH];
    logic [LENW-1:0] len_a    [NCH];

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_lane
            assign addr_a[gi]   = ireq_addr[gi*AW +: AW];
            assign size_a[gi]   = ireq_size[gi*3 +: 3];
            assign strobe_a[gi] = ireq_strobe[gi*BW +: BW];
            assign data_a[gi]   = ireq_data[gi*DW +: DW];
            assign len_a[gi]    = ireq_len[gi*LENW +: LENW];

            cbus_arb_lane u_lane (
                .hit         (busy && (sel == SW'(gi))),
                .oresp_ready (oresp_ready),
                .oresp_last  (oresp_last),
                .resp_ready  (iresp_ready[gi]),
                .resp_last   (iresp_last[gi])
            );
        end
    endgenerate

    // Winner search: walk channels starting at base, first requester wins.
    int            base;
    logic          found;
    logic [SW-1:0] win;

`ifdef CBUS_ARB_RR_EN
    assign base = (int'(last_grant) + 1) % NCH;
`else
    assign base = 0;
    // last_grant is kept in both builds so the register set does not change.
    logic unused_last_grant;
    assign unused_last_grant = ^last_grant;
`endif

    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < NCH; k++) begin
            int idx;
            idx = (base + k) % NCH;
            if (!found && ireq_valid[idx]) begin
                found = 1'b1;
                win   = idx[SW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            sel        <= '0;
            last_grant <= SW'(NCH - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state      <= BUSY;
                        sel        <= win;
                        last_grant <= win;
                    end
                end
                BUSY: begin
                    // Final beat, or the granted master dropped valid mid-transaction.
                    if (!ireq_valid[sel] || (oresp_ready && oresp_last))
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy          = (state == BUSY);
    assign grant_idx     = sel;
    assign oreq_valid    = busy & ireq_valid[sel];
    assign oreq_is_write = ireq_is_write[sel];
    assign oreq_addr     = addr_a[sel];
    assign oreq_size     = size_a[sel];
    assign oreq_strobe   = strobe_a[sel];
    assign oreq_data     = data_a[sel];
    assign oreq_len      = len_a[sel];
    assign iresp_data    = oresp_data;

endmodule

// File: tb/tb_cbus_arbiter_n.sv
// Scoreboard bench for cbus_arbiter_n (NCH=3). Stimulus pushes the expected beat;
// a negedge monitor pops and compares whenever any iresp_ready bit is high.
module tb_cbus_arbiter_n;
    localparam int NCH = 3, AW = 32, DW = 32, LENW = 4, BW = DW / 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [NCH-1:0]        ireq_valid, ireq_is_write;
    logic [NCH*AW-1:0]     ireq_addr;
    logic [NCH*3-1:0]      ireq_size;
    logic [NCH*BW-1:0]     ireq_strobe;
    logic [NCH*DW-1:0]     ireq_data;
    logic [NCH*LENW-1:0]   ireq_len;
    logic [NCH-1:0]        iresp_ready, iresp_last;
    logic [DW-1:0]         iresp_data;
    logic                  oreq_valid, oreq_is_write;
    logic [AW-1:0]         oreq_addr;
    logic [2:0]            oreq_size;
    logic [BW-1:0]         oreq_strobe;
    logic [DW-1:0]         oreq_data;
    logic [LENW-1:0]       oreq_len;
    logic                  oresp_ready, oresp_last;
    logic [DW-1:0]         oresp_data;
    logic                  busy;
    logic [$clog2(NCH)-1:0] grant_idx;

    cbus_arbiter_n #(.NCH(NCH), .AW(AW), .DW(DW), .LENW(LENW)) dut (
        .clk(clk), .reset(reset),
        .ireq_valid(ireq_valid), .ireq_is_write(ireq_is_write), .ireq_addr(ireq_addr),
        .ireq_size(ireq_size), .ireq_strobe(ireq_strobe), .ireq_data(ireq_data),
        .ireq_len(ireq_len), .iresp_ready(iresp_ready), .iresp_last(iresp_last),
        .iresp_data(iresp_data), .oreq_valid(oreq_valid), .oreq_is_write(oreq_is_write),
        .oreq_addr(oreq_addr), .oreq_size(oreq_size), .oreq_strobe(oreq_strobe),
        .oreq_data(oreq_data), .oreq_len(oreq_len), .oresp_ready(oresp_ready),
        .oresp_last(oresp_last), .oresp_data(oresp_data), .busy(busy), .grant_idx(grant_idx)
    );

    typedef struct {
        int         idx;
        logic       wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0] len;
        logic [2:0] rdy;
        logic [2:0] lst;
        logic [31:0] rdata;
    } beat_t;

    beat_t sbq[$];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int i, input logic v, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] l);
        ireq_valid[i]             = v;
        ireq_is_write[i]          = wr;
        ireq_addr[i*AW +: AW]     = a;
        ireq_data[i*DW +: DW]     = d;
        ireq_len[i*LENW +: LENW]  = l;
        ireq_size[i*3 +: 3]       = 3'd2;
        ireq_strobe[i*BW +: BW]   = wr ? {BW{1'b1}} : {BW{1'b0}};
    endtask

    // Drive one downstream beat and record what the DUT must present for it.
    task automatic beat(input int idx, input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] l, input logic last, input logic [31:0] rdata);
        beat_t b;
        b.idx = idx; b.wr = wr; b.addr = a; b.wdata = d; b.len = l;
        b.rdy = 3'b001 << idx;
        b.lst = last ? (3'b001 << idx) : 3'b000;
        b.rdata = rdata;
        sbq.push_back(b);
        oresp_ready = 1'b1;
        oresp_last  = last;
        oresp_data  = rdata;
    endtask

    task automatic down_idle();
        oresp_ready = 1'b0;
        oresp_last  = 1'b0;
        oresp_data  = '0;
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "_busy"}, 64'(busy), 64'd0);
        chk({nm, "_oreq_valid"}, 64'(oreq_valid), 64'd0);
        chk({nm, "_iresp_ready"}, 64'(iresp_ready), 64'd0);
        chk({nm, "_iresp_last"}, 64'(iresp_last), 64'd0);
    endtask

    task automatic chk_grant(input string nm, input int idx, input logic [31:0] a);
        chk({nm, "_busy"}, 64'(busy), 64'd1);
        chk({nm, "_grant"}, 64'(grant_idx), 64'(idx));
        chk({nm, "_oreq_valid"}, 64'(oreq_valid), 64'd1);
        chk({nm, "_addr"}, 64'(oreq_addr), 64'(a));
    endtask

    // Monitor: every beat steered to a master must match the next scoreboard entry.
    always @(negedge clk) begin
        if (iresp_ready != '0) begin
            if (sbq.size() == 0) begin
                chk("unexpected_beat", 64'(iresp_ready), 64'd0);
            end else begin
                beat_t e;
                e = sbq.pop_front();
                chk("mon_grant", 64'(grant_idx), 64'(e.idx));
                chk("mon_valid", 64'(oreq_valid), 64'd1);
                chk("mon_wr", 64'(oreq_is_write), 64'(e.wr));
                chk("mon_addr", 64'(oreq_addr), 64'(e.addr));
                chk("mon_wdata", 64'(oreq_data), 64'(e.wdata));
                chk("mon_len", 64'(oreq_len), 64'(e.len));
                chk("mon_size", 64'(oreq_size), 64'd2);
                chk("mon_iresp_ready", 64'(iresp_ready), 64'(e.rdy));
                chk("mon_iresp_last", 64'(iresp_last), 64'(e.lst));
                chk("mon_iresp_data", 64'(iresp_data), 64'(e.rdata));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

`ifdef CBUS_ARB_RR_EN
    int rr_exp[4] = '{0, 1, 0, 1};
`else
    int rr_exp[4] = '{0, 0, 0, 0};
`endif

    logic [31:0] wd[4] = '{32'h11, 32'h22, 32'h33, 32'h44};

    initial begin
        reset = 1'b1;
        ireq_valid = '0; ireq_is_write = '0; ireq_addr = '0; ireq_size = '0;
        ireq_strobe = '0; ireq_data = '0; ireq_len = '0;
        down_idle();
        tick(); tick();
        chk_idle("reset");
        chk("reset_grant", 64'(grant_idx), 64'd0);
        reset = 1'b0;

        // 1: single read on ch1
        set_ch(1, 1, 0, 32'h1FC0_0000, 0, 0);
        chk("t1_pre_valid", 64'(oreq_valid), 64'd0);
        tick();
        chk_grant("t1", 1, 32'h1FC0_0000);
        beat(1, 0, 32'h1FC0_0000, 0, 0, 1, 32'hDEAD_BEEF);
        tick();
        set_ch(1, 0, 0, 0, 0, 0);
        down_idle();
        chk_idle("t1_after");

        // 2: contention, lower index first, then a bubble
        set_ch(0, 1, 0, 32'hA000_0000, 0, 0);
        set_ch(1, 1, 0, 32'hA100_0000, 0, 0);
        tick();
        chk_grant("t2_first", 0, 32'hA000_0000);
        beat(0, 0, 32'hA000_0000, 0, 0, 1, 32'h0000_C0DE);
        tick();
        set_ch(0, 0, 0, 0, 0, 0);
        // Downstream handshake left high through the bubble: must not reach any master.
        chk_idle("t2_bubble");
        tick();
        chk_grant("t2_second", 1, 32'hA100_0000);
        beat(1, 0, 32'hA100_0000, 0, 0, 1, 32'h0000_BEEF);
        tick();
        set_ch(1, 0, 0, 0, 0, 0);
        down_idle();
        chk_idle("t2_after");

        // 3: write burst, data changes each beat
        set_ch(0, 1, 1, 32'h0000_1000, wd[0], 4'd3);
        tick();
        chk_grant("t3", 0, 32'h0000_1000);
        for (int b = 0; b < 4; b++) begin
            ireq_data[0 +: DW] = wd[b];
            beat(0, 1, 32'h0000_1000, wd[b], 4'd3, b == 3, 0);
            tick();
        end
        set_ch(0, 0, 0, 0, 0, 0);
        down_idle();
        chk_idle("t3_after");

        // 4: policy check from a fresh reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_ch(0, 1, 0, 32'hB000_0000, 0, 0);
        set_ch(1, 1, 0, 32'hB100_0000, 0, 0);
        for (int n = 0; n < 4; n++) begin
            logic [31:0] a;
            tick();
            a = (rr_exp[n] == 0) ? 32'hB000_0000 : 32'hB100_0000;
            chk_grant($sformatf("t4_seq%0d", n), rr_exp[n], a);
            beat(rr_exp[n], 0, a, 0, 0, 1, 32'h100 + n);
            tick();
            down_idle();
        end
        set_ch(0, 0, 0, 0, 0, 0);
        set_ch(1, 0, 0, 0, 0, 0);
        tick();

        // 5: reset on beat 2 of a 4-beat read, ch1 pending
        set_ch(0, 1, 0, 32'h0000_2000, 0, 4'd3);
        set_ch(1, 1, 0, 32'h0000_3000, 0, 0);
        tick();
        chk_grant("t5", 0, 32'h0000_2000);
        beat(0, 0, 32'h0000_2000, 0, 4'd3, 0, 32'h5001);
        tick();
        beat(0, 0, 32'h0000_2000, 0, 4'd3, 0, 32'h5002);
        reset = 1'b1;
        tick();
        chk_idle("t5_reset");
        chk("t5_reset_grant", 64'(grant_idx), 64'd0);
        reset = 1'b0;
        set_ch(0, 0, 0, 0, 0, 0);
        down_idle();
        for (int n = 0; n < 2; n++) begin
            tick();
            if (busy) break;
        end
        chk_grant("t5_pending", 1, 32'h0000_3000);
        beat(1, 0, 32'h0000_3000, 0, 0, 1, 32'h5003);
        tick();
        set_ch(1, 0, 0, 0, 0, 0);
        down_idle();
        chk_idle("t5_after");

        // 6: ch2 arrives while ch0 runs a 2-beat read
        set_ch(0, 1, 0, 32'h0000_4000, 0, 4'd1);
        tick();
        chk_grant("t6_ch0", 0, 32'h0000_4000);
        set_ch(2, 1, 0, 32'h0000_5000, 0, 0);
        beat(0, 0, 32'h0000_4000, 0, 4'd1, 0, 32'h6001);
        tick();
        beat(0, 0, 32'h0000_4000, 0, 4'd1, 1, 32'h6002);
        tick();
        set_ch(0, 0, 0, 0, 0, 0);
        down_idle();
        chk_idle("t6_bubble");
        tick();
        chk_grant("t6_ch2", 2, 32'h0000_5000);
        beat(2, 0, 32'h0000_5000, 0, 0, 1, 32'h6003);
        tick();
        set_ch(2, 0, 0, 0, 0, 0);
        down_idle();
        chk_idle("t6_after");

        // Master abort: dropping valid while granted returns to IDLE
        set_ch(1, 1, 0, 32'h0000_7000, 0, 4'd2);
        tick();
        chk_grant("abort", 1, 32'h0000_7000);
        set_ch(1, 0, 0, 0, 0, 0);
        tick();
        chk_idle("abort_after");

        tick();
        chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
